// File: rtl/i2c_master_gen.sv
// I2C write-only master. Sends up to MAX_BYTES bytes (address byte first) with
// START/STOP framing; each SCL bit spans four quarters of CLK_DIV clock cycles.
// Optional macro I2C_ACK_CHECK_EN: sample the slave ACK, flag NACK in ack_err_o
// and cut the transaction short to STOP.
module i2c_master_gen #(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned MAX_BYTES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   go_i,
  input  logic [2:0]             len_i,
  input  logic [8*MAX_BYTES-1:0] i2c_data_i,
  output logic                   i2c_sclk_o,
  inout  wire                    i2c_sdat_io,
  output logic                   busy_o,
  output logic                   end_o,
  output logic                   ack_err_o
);

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StDone} state_e;

  localparam int unsigned DW       = 8 * MAX_BYTES;
  localparam logic [9:0]  DivLast  = 10'(CLK_DIV - 1);
  localparam logic [2:0]  MaxLen   = 3'(MAX_BYTES);
  // The GO cycle stands in for the first START cycle and DONE for the last STOP
  // cycle, so START is entered one cycle in and STOP is left one cycle early.
  localparam logic [9:0]  StopDiv  = (CLK_DIV > 1) ? 10'(CLK_DIV - 2) : 10'd0;
  localparam logic [1:0]  StopQtr  = (CLK_DIV > 1) ? 2'd2 : 2'd1;
  localparam logic [9:0]  StartDiv = (CLK_DIV > 1) ? 10'd1 : 10'd0;
  localparam logic [1:0]  StartQtr = (CLK_DIV > 1) ? 2'd0 : 2'd1;

  state_e          state_q, state_d;
  logic [9:0]      div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      rem_q, rem_d;
  logic [DW-1:0]   data_q, data_d;
  logic            qtr_end;
  logic            sda_low;

  assign qtr_end = (div_q == DivLast);

`ifdef I2C_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  assign ack_err_o = ack_err_q;
`else
  assign ack_err_o = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
`ifdef I2C_ACK_CHECK_EN
      ack_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
`ifdef I2C_ACK_CHECK_EN
      ack_err_q <= ack_err_d;
`endif
    end
  end

  // Next-state: quarter timing, bit/byte sequencing, request latching
  always_comb begin
    state_d   = state_q;
    div_d     = qtr_end ? 10'd0 : div_q + 10'd1;
    qtr_d     = qtr_end ? qtr_q + 2'd1 : qtr_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    data_d    = data_q;
`ifdef I2C_ACK_CHECK_EN
    ack_err_d = ack_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        div_d = 10'd0;
        qtr_d = 2'd0;
        if (go_i) begin
          state_d = StStart;
          div_d   = StartDiv;
          qtr_d   = StartQtr;
          data_d  = i2c_data_i;
          if (len_i == 3'd0)        rem_d = 3'd1;
          else if (len_i > MaxLen)  rem_d = MaxLen;
          else                      rem_d = len_i;
`ifdef I2C_ACK_CHECK_EN
          ack_err_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (qtr_end && qtr_q == 2'd1) begin
          state_d = StBit;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
        end
      end
      StBit: begin
        if (qtr_end && qtr_q == 2'd3) begin
          data_d = data_q << 1;
          if (bit_q == 3'd7) state_d = StAck;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StAck: begin
`ifdef I2C_ACK_CHECK_EN
        if (qtr_end && qtr_q == 2'd2 && i2c_sdat_io == 1'b1) ack_err_d = 1'b1;
        if (qtr_end && qtr_q == 2'd3) begin
          if (rem_q == 3'd1 || ack_err_q) begin
            state_d = StStop;
          end else begin
            state_d = StBit;
            rem_d   = rem_q - 3'd1;
            bit_d   = 3'd0;
          end
        end
`else
        if (qtr_end && qtr_q == 2'd3) begin
          if (rem_q == 3'd1) begin
            state_d = StStop;
          end else begin
            state_d = StBit;
            rem_d   = rem_q - 3'd1;
            bit_d   = 3'd0;
          end
        end
`endif
      end
      StStop: begin
        if (qtr_q == StopQtr && div_q == StopDiv) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        div_d   = 10'd0;
        qtr_d   = 2'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus and status outputs decoded from state and quarter
  always_comb begin
    i2c_sclk_o = 1'b1;
    sda_low    = 1'b0;
    busy_o     = 1'b0;
    end_o      = 1'b0;
    unique case (state_q)
      StIdle: ;
      StStart: begin
        busy_o  = 1'b1;
        sda_low = (qtr_q == 2'd1);
      end
      StBit: begin
        busy_o     = 1'b1;
        i2c_sclk_o = qtr_q[1];
        sda_low    = ~data_q[DW-1];
      end
      StAck: begin
        busy_o     = 1'b1;
        i2c_sclk_o = qtr_q[1];
      end
      StStop: begin
        busy_o     = 1'b1;
        i2c_sclk_o = (qtr_q != 2'd0);
        sda_low    = (qtr_q != 2'd2);
      end
      StDone:  end_o = 1'b1;
      default: ;
    endcase
  end

  // Open-drain data line
  assign i2c_sdat_io = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_gen.sv
// Bench for i2c_master_gen (CLK_DIV=2, MAX_BYTES=3) with a bus monitor, an ACKing
// slave and a byte-level reference model of each transaction.
module tb_i2c_master_gen;

  localparam int unsigned CD = 2;
  localparam int unsigned MB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [2:0]    len;
  logic [23:0]   data;
  logic          scl, busy, endp, ack_err;
  wire           sda;
  logic          slave_drive = 1'b0;

  int            npass = 0;
  int            ntot  = 0;

  // Monitor / slave state
  logic          prev_scl = 1'b1;
  logic          prev_sda = 1'b1;
  int            bitcnt   = 0;
  int            byte_idx = 0;
  int            starts   = 0;
  int            stops    = 0;
  int            nack_byte = 0;
  logic          obs_bits[$];

`ifdef I2C_ACK_CHECK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  pullup (sda);
  assign sda = slave_drive ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_gen #(.CLK_DIV(CD), .MAX_BYTES(MB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .go_i       (go),
    .len_i      (len),
    .i2c_data_i (data),
    .i2c_sclk_o (scl),
    .i2c_sdat_io(sda),
    .busy_o     (busy),
    .end_o      (endp),
    .ack_err_o  (ack_err)
  );

  // Bus monitor and slave: decode START/STOP, record bits on SCL rise, ACK bytes
  always @(negedge clk) begin
    if (rst) begin
      prev_scl    <= 1'b1;
      prev_sda    <= 1'b1;
      slave_drive <= 1'b0;
    end else begin
      prev_scl <= scl;
      prev_sda <= sda;
      if (prev_scl && scl && prev_sda && !sda) begin
        starts      <= starts + 1;
        bitcnt      <= 0;
        byte_idx    <= 0;
        slave_drive <= 1'b0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        stops       <= stops + 1;
        slave_drive <= 1'b0;
        void'(obs_bits.pop_back());  // the STOP's own SCL rise is not a data bit
      end else if (!prev_scl && scl) begin
        obs_bits.push_back(sda);
        bitcnt <= bitcnt + 1;
      end else if (prev_scl && !scl) begin
        if (bitcnt == 8) begin
          slave_drive <= (byte_idx + 1 != nack_byte);
        end else if (bitcnt == 9) begin
          slave_drive <= 1'b0;
          bitcnt      <= 0;
          byte_idx    <= byte_idx + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One transaction against the reference model; disturb pulses GO and alters inputs mid-way
  task automatic run_txn(input logic [23:0] d, input logic [2:0] l, input int nk,
                         input bit disturb, input string tag);
    int   n, sent, exp_end, cyc, base, s0, p0, nobs;
    logic exp_err;
    logic exp_bits[$];
    logic [7:0] b;
    n    = (l == 3'd0) ? 1 : ((int'(l) > int'(MB)) ? int'(MB) : int'(l));
    sent = n;
    exp_err = 1'b0;
    if (AckEn && nk >= 1 && nk <= n) begin
      sent    = nk;
      exp_err = 1'b1;
    end
    for (int i = 0; i < sent; i++) begin
      b = d[8*(int'(MB)-1-i) +: 8];
      for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
      exp_bits.push_back(i + 1 == nk);
    end
    exp_end = int'(CD) * (5 + 36 * sent);

    nack_byte = nk;
    base = obs_bits.size();
    s0 = starts;
    p0 = stops;
    go   = 1'b1;
    data = d;
    len  = l;
    cyc  = 1;
    step();
    cyc = 2;
    go  = 1'b0;
    chk({tag, ".busy_after_go"}, busy, 1'b1);
    chk({tag, ".ack_err_cleared"}, ack_err, 1'b0);
    while (!endp && cyc < 2000) begin
      step();
      cyc++;
      if (disturb && cyc == 20) begin
        go   = 1'b1;
        data = ~d;
        len  = 3'($urandom_range(0, 7));
      end
      if (disturb && cyc == 26) go = 1'b0;
    end
    chk({tag, ".end_cycle"}, cyc, exp_end);
    chk({tag, ".busy_at_end"}, busy, 1'b0);
    chk({tag, ".ack_err"}, ack_err, exp_err);
    step();
    step();
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".idle_line"}, {scl, sda}, 2'b11);
    chk({tag, ".ack_err_hold"}, ack_err, exp_err);
    chk({tag, ".starts"}, starts - s0, 1);
    chk({tag, ".stops"}, stops - p0, 1);
    nobs = obs_bits.size() - base;
    chk({tag, ".nbits"}, nobs, exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < nobs; i++)
      chk($sformatf("%s.bit%0d", tag, i), obs_bits[base+i], exp_bits[i]);
  endtask

  initial begin
    int bad, p0;
    rst  = 1'b1;
    go   = 1'b0;
    len  = 3'd0;
    data = '0;
    step();
    step();
    chk("reset.scl", scl, 1'b1);
    chk("reset.sda", sda, 1'b1);
    chk("reset.busy", busy, 1'b0);
    chk("reset.end", endp, 1'b0);
    chk("reset.ack_err", ack_err, 1'b0);
    rst = 1'b0;
    step();
    step();
    chk("idle.line", {scl, sda, busy}, 3'b110);

    run_txn(24'h341E5A, 3'd3, 0, 1'b0, "len3");
    run_txn(24'($urandom), 3'd0, 0, 1'b0, "len0");
    run_txn(24'($urandom), 3'd7, 0, 1'b0, "len7");
    run_txn(24'h341E5A, 3'd3, 1, 1'b0, "nack1");
    run_txn(24'($urandom), 3'd3, 0, 1'b1, "go_busy");

    // Reset mid-byte (SCL low in bit 3 of byte 1): immediate release, no STOP
    p0   = stops;
    go   = 1'b1;
    data = 24'hA5C33C;
    len  = 3'd3;
    step();
    go = 1'b0;
    for (int i = 2; i < 30; i++) step();
    rst = 1'b1;
    #1;
    chk("abort.scl", scl, 1'b1);
    chk("abort.sda", sda, 1'b1);
    chk("abort.busy", busy, 1'b0);
    chk("abort.end", endp, 1'b0);
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || endp !== 1'b0) bad++;
    end
    chk("abort.stays_idle", bad, 0);
    chk("abort.no_stop", stops - p0, 0);

    for (int t = 0; t < 6; t++) begin
      run_txn(24'($urandom), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
              1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
